// File: rtl/mem_pipe_if.sv
// Request/response bus for mem_pipe: valid/ready request channel, fixed-latency
// read response channel and the init-complete flag.
interface mem_pipe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/mem_pipe.sv
// Single-port data memory with valid/ready requests and an RD_LATENCY read pipeline.
// Define MEM_INIT_EN to add the post-reset clear sequencer (array zeroed after every reset).
module mem_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_pipe_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_accept    = bus.req_valid && r_req_ready;
  assign w_rd_accept = w_accept && !bus.req_write;

`ifdef MEM_INIT_EN
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_last;

  // MSB stays clear during the sweep; the all-ones address marks the final clear write
  assign w_cnt_last = !r_cnt[ADDR_WIDTH] && (r_cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_cnt_last) begin
            r_state     <= ST_RUN;
            r_req_ready <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state     <= ST_INIT;
          r_req_ready <= 1'b0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end
`else
  // No clear sweep: usable from the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state     <= ST_RUN;
          r_req_ready <= 1'b1;
          r_init_done <= 1'b1;
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state     <= ST_INIT;
          r_req_ready <= 1'b0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Array write port: clear sweep during INIT, accepted writes during RUN
  always_comb begin
    w_mem_we    = w_accept && bus.req_write;
    w_mem_addr  = bus.req_addr;
    w_mem_wdata = bus.req_wdata;
`ifdef MEM_INIT_EN
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt[ADDR_WIDTH-1:0];
      w_mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Read data captured at accept, then shifted; output data only moves with a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_pipe_data[k] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_accept;
      if (w_rd_accept) begin
        r_pipe_data[0] <= r_mem[bus.req_addr];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_data[k] <= r_pipe_data[k-1];
        end
      end
      r_rsp_valid <= r_pipe_vld[RD_LATENCY-1];
      if (r_pipe_vld[RD_LATENCY-1]) begin
        r_rsp_rdata <= r_pipe_data[RD_LATENCY-1];
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.init_done = r_init_done;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_mem_pipe.sv
// Randomized scoreboard bench for mem_pipe (DATA_WIDTH=16, RD_LATENCY=3);
// adapts its expectations to whether MEM_INIT_EN is defined.
module tb_mem_pipe;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned RL    = 3;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef MEM_INIT_EN
  localparam int EXP_READY = DEPTH;
`else
  localparam int EXP_READY = 1;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  logic [DW-1:0] exp_q   [$];
  int            t_q     [$];
  logic [DW-1:0] exp_hold;

  mem_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents as seen from outside after a reset
  task automatic model_reset();
    exp_q.delete();
    t_q.delete();
    exp_hold = '0;
    for (int a = 0; a < DEPTH; a++) begin
`ifdef MEM_INIT_EN
      ref_mem[a] = '0;
      known[a]   = 1'b1;
`else
      ref_mem[a] = 'x;
      known[a]   = 1'b0;
`endif
    end
  endtask

  // Issue one request once ready is seen; reads queue the value the array holds now
  task automatic do_req(input bit wr, input int a, input logic [DW-1:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1) begin
      guard++;
      if (guard > 200) begin
        check("req_ready_timeout", 64'(bus.req_ready), 64'(1));
        return;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = AW'(a);
    bus.req_wdata = d;
    if (wr) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
    end else begin
      exp_q.push_back(ref_mem[a]);
      t_q.push_back(cyc + 1 + RL);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic count_to_ready(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.req_ready !== 1'b1 && n < 200);
    bus.req_valid = 1'b0;
    check(name, 64'(n), 64'(EXP_READY));
    check({name, "_init_done"}, 64'(bus.init_done), 64'(1));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({name, "_init_done"}, 64'(bus.init_done), 64'(0));
    check({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({name, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
  endtask

  // Monitor: every response must match the oldest queued read, at its due cycle
  always @(negedge clk) begin
    if (bus.rsp_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b want 0 (cycle %0d)", bus.rsp_valid, cyc);
      end else begin
        logic [DW-1:0] d;
        int            t;
        d = exp_q.pop_front();
        t = t_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(d));
        check("rsp_cycle", 64'(cyc), 64'(t));
        exp_hold = d;
      end
    end else if (rst_n === 1'b1) begin
      check("rdata_hold", 64'(bus.rsp_rdata), 64'(exp_hold));
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();

    // Read request held during reset must be ignored
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Write held through the not-ready window must never land
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = AW'(7);
    bus.req_wdata = 16'hFFFF;
    rst_n = 1'b1;
    count_to_ready("ready_after_reset");

`ifdef MEM_INIT_EN
    do_req(1'b0, 0, '0);
    do_req(1'b0, 17, '0);
    do_req(1'b0, 31, '0);
    do_req(1'b0, 7, '0);
`endif

    do_req(1'b1, 3, 16'h00A5);
    do_req(1'b0, 3, '0);
    do_req(1'b1, 1, 16'h1234);
    do_req(1'b1, 2, 16'h5678);
    do_req(1'b0, 1, '0);
    do_req(1'b0, 2, '0);
    do_req(1'b0, 1, '0);
    do_req(1'b1, 5, 16'h0011);
    do_req(1'b0, 5, '0);
    do_req(1'b1, 5, 16'h0022);
    do_req(1'b0, 5, '0);
    do_req(1'b1, 31, 16'h003C);
    do_req(1'b0, 31, '0);

    for (int i = 0; i < 300; i++) begin
      bit wr;
      int a;
      wr = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, DEPTH - 1));
      if (!wr && !known[a]) wr = 1'b1;
      do_req(wr, a, DW'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (RL + 3) @(negedge clk);
    check("drain_random", 64'(exp_q.size()), 64'(0));

    // Reset with two reads in flight: both must vanish
    do_req(1'b0, 1, '0);
    do_req(1'b0, 2, '0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_inflight");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_to_ready("ready_after_inflight_reset");

`ifdef MEM_INIT_EN
    // Reset in the middle of the clear sweep restarts it from scratch
    do_req(1'b1, 31, 16'hBEEF);
    do_req(1'b1, 17, 16'hCAFE);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_init");
    @(negedge clk);
    rst_n = 1'b1;
    count_to_ready("ready_after_mid_init");
    do_req(1'b0, 0, '0);
    do_req(1'b0, 17, '0);
    do_req(1'b0, 31, '0);
`else
    do_req(1'b1, 31, 16'h003C);
    do_req(1'b0, 31, '0);
`endif

    repeat (RL + 3) @(negedge clk);
    check("drain_final", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
